// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// reorder_buffer_pkg : shared types, sizes and helpers for the reorder buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reorder_buffer_pkg;

   localparam int ROB_WIDTH  = 4;
   localparam int REG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;
   localparam int ROB_DEPTH  = 2 ** ROB_WIDTH;

   typedef logic [ROB_WIDTH:0] rob_ptr_t;

   typedef struct packed {
      logic                  valid;
      logic [ROB_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } cdb_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_WIDTH-1:0]  arch_num;
      logic [DATA_WIDTH-1:0] data;
   } rob_entry;

   function automatic logic tag_match(input cdb_t c, input logic [ROB_WIDTH-1:0] t);
      return c.valid && (c.tag == t);
   endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_read_port.sv
// ---------------------------------------------------------------------------
// reorder_buffer_read_port : tag-indexed operand lookup with CDB bypass
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reorder_buffer_read_port
   import reorder_buffer_pkg::*;
(
   input  logic [ROB_WIDTH-1:0]                 rd_tag,
   input  logic [ROB_DEPTH-1:0]                 ent_valid,
   input  logic [ROB_DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
   input  cdb_t                                 cdb,
   output logic                                 rd_valid,
   output logic [DATA_WIDTH-1:0]                rd_data
);

   logic hit;

   always_comb begin
      hit      = tag_match(cdb, rd_tag);
      rd_valid = ent_valid[rd_tag] || hit;
      // The broadcast is the newest value for this tag, so it wins the mux.
      rd_data  = hit ? cdb.data : ent_data[rd_tag];
   end

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer : 16-entry in-order retirement queue with CDB writeback
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  alloc_req,
   input  logic [REG_WIDTH-1:0]  alloc_arch_num,
   output logic                  alloc_ready,
   output logic [ROB_WIDTH-1:0]  alloc_tag,
   input  cdb_t                  cdb,
   input  logic [ROB_WIDTH-1:0]  rd_tag   [2],
   output logic                  rd_valid [2],
   output logic [DATA_WIDTH-1:0] rd_data  [2],
   output logic                  commit_valid,
   output logic [REG_WIDTH-1:0]  commit_arch_num,
   output logic [DATA_WIDTH-1:0] commit_data,
   output logic [ROB_WIDTH-1:0]  commit_tag,
   output logic [ROB_WIDTH:0]    count
);

   rob_ptr_t                 head_q, head_d;
   rob_ptr_t                 tail_q, tail_d;
   rob_entry [ROB_DEPTH-1:0] ent_q;

   logic                                 empty;
   logic                                 full;
   logic                                 do_alloc;
   logic                                 do_commit;
   logic                                 cdb_hit;
   logic [ROB_WIDTH-1:0]                 head_idx;
   logic [ROB_WIDTH-1:0]                 tail_idx;
   logic [ROB_WIDTH-1:0]                 cdb_offset;
   logic [ROB_DEPTH-1:0]                 ent_valid;
   logic [ROB_DEPTH-1:0][DATA_WIDTH-1:0] ent_data;

   always_comb begin
      head_idx        = head_q[ROB_WIDTH-1:0];
      tail_idx        = tail_q[ROB_WIDTH-1:0];
      count           = tail_q - head_q;
      empty           = (head_q == tail_q);
      full            = (head_idx == tail_idx) && (head_q[ROB_WIDTH] != tail_q[ROB_WIDTH]);
      alloc_ready     = !full;
      alloc_tag       = tail_idx;
      commit_valid    = !empty && ent_q[head_idx].valid;
      commit_arch_num = ent_q[head_idx].arch_num;
      commit_data     = ent_q[head_idx].data;
      commit_tag      = head_idx;
      do_alloc        = alloc_req && alloc_ready;
      do_commit       = commit_valid;
      // Distance from head below occupancy means the tag is currently in flight.
      cdb_offset      = cdb.tag - head_idx;
      cdb_hit         = cdb.valid && ({1'b0, cdb_offset} < count);
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (do_alloc)  tail_d = tail_q + rob_ptr_t'(1);
         if (do_commit) head_d = head_q + rob_ptr_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            if (flush) begin
               ent_q[i].valid <= 1'b0;
            end else begin
               if (do_alloc && (tail_idx == ROB_WIDTH'(i))) begin
                  ent_q[i].valid    <= 1'b0;
                  ent_q[i].arch_num <= alloc_arch_num;
                  ent_q[i].data     <= '0;
               end
               if (cdb_hit && (cdb.tag == ROB_WIDTH'(i))) begin
                  ent_q[i].valid <= 1'b1;
                  ent_q[i].data  <= cdb.data;
               end
               // Retirement last so a late duplicate broadcast cannot revive the slot.
               if (do_commit && (head_idx == ROB_WIDTH'(i))) begin
                  ent_q[i].valid <= 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
         ent_valid[i] = ent_q[i].valid;
         ent_data[i]  = ent_q[i].data;
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd_port
      reorder_buffer_read_port u_rd (
         .rd_tag    (rd_tag[p]),
         .ent_valid (ent_valid),
         .ent_data  (ent_data),
         .cdb       (cdb),
         .rd_valid  (rd_valid[p]),
         .rd_data   (rd_data[p])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer : directed self-checking bench for reorder_buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  flush = 1'b0;
   logic                  alloc_req = 1'b0;
   logic [REG_WIDTH-1:0]  alloc_arch_num = '0;
   logic                  alloc_ready;
   logic [ROB_WIDTH-1:0]  alloc_tag;
   cdb_t                  cdb = '0;
   logic [ROB_WIDTH-1:0]  rd_tag   [2];
   logic                  rd_valid [2];
   logic [DATA_WIDTH-1:0] rd_data  [2];
   logic                  commit_valid;
   logic [REG_WIDTH-1:0]  commit_arch_num;
   logic [DATA_WIDTH-1:0] commit_data;
   logic [ROB_WIDTH-1:0]  commit_tag;
   logic [ROB_WIDTH:0]    count;

   int n_checks = 0;
   int n_errors = 0;

   reorder_buffer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .alloc_req       (alloc_req),
      .alloc_arch_num  (alloc_arch_num),
      .alloc_ready     (alloc_ready),
      .alloc_tag       (alloc_tag),
      .cdb             (cdb),
      .rd_tag          (rd_tag),
      .rd_valid        (rd_valid),
      .rd_data         (rd_data),
      .commit_valid    (commit_valid),
      .commit_arch_num (commit_arch_num),
      .commit_data     (commit_data),
      .commit_tag      (commit_tag),
      .count           (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rd_tag[0] = '0;
      rd_tag[1] = '0;
      #12;
      rst_n = 1'b1;
      tick();
      #1;

      // 1: reset state and first allocations
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rd_valid0", 32'(rd_valid[0]), 32'd0);
      chk("rst_rd_valid1", 32'(rd_valid[1]), 32'd0);
      alloc_req = 1'b1; alloc_arch_num = 5'd3; #1;
      chk("t1_tag0", 32'(alloc_tag), 32'd0);
      tick(); alloc_arch_num = 5'd5; #1;
      chk("t1_tag1", 32'(alloc_tag), 32'd1);
      tick(); alloc_arch_num = 5'd7; #1;
      chk("t1_tag2", 32'(alloc_tag), 32'd2);
      tick(); alloc_req = 1'b0; #1;
      chk("t1_count", 32'(count), 32'd3);
      chk("t1_no_commit", 32'(commit_valid), 32'd0);

      // 2: out-of-order completion, in-order commit
      cdb = '{valid: 1'b1, tag: 4'd1, data: 32'hAA}; #1;
      chk("t2_no_commit_a", 32'(commit_valid), 32'd0);
      tick(); cdb = '{valid: 1'b1, tag: 4'd0, data: 32'h55}; #1;
      chk("t2_no_commit_b", 32'(commit_valid), 32'd0);
      tick(); cdb = '0; #1;
      chk("t2_c0_valid", 32'(commit_valid), 32'd1);
      chk("t2_c0_arch", 32'(commit_arch_num), 32'd3);
      chk("t2_c0_data", commit_data, 32'h55);
      chk("t2_c0_tag", 32'(commit_tag), 32'd0);
      tick(); #1;
      chk("t2_c1_valid", 32'(commit_valid), 32'd1);
      chk("t2_c1_arch", 32'(commit_arch_num), 32'd5);
      chk("t2_c1_data", commit_data, 32'hAA);
      tick(); #1;
      chk("t2_head2_novalid", 32'(commit_valid), 32'd0);
      chk("t2_head2_tag", 32'(commit_tag), 32'd2);
      chk("t2_count", 32'(count), 32'd1);

      // 3: fill to 16, then alloc refused while head commits
      alloc_req = 1'b1;
      for (int i = 0; i < 15; i++) begin
         alloc_arch_num = 5'(i); #1;
         chk("t3_fill_tag", 32'(alloc_tag), 32'((3 + i) % 16));
         tick();
      end
      #1;
      chk("t3_full_ready", 32'(alloc_ready), 32'd0);
      chk("t3_full_count", 32'(count), 32'd16);
      cdb = '{valid: 1'b1, tag: 4'd2, data: 32'hBEEF};
      tick(); cdb = '0; #1;
      chk("t3_refuse_ready", 32'(alloc_ready), 32'd0);
      chk("t3_commit_valid", 32'(commit_valid), 32'd1);
      chk("t3_commit_data", commit_data, 32'hBEEF);
      tick(); alloc_req = 1'b0; #1;
      chk("t3_count15", 32'(count), 32'd15);
      chk("t3_ready_again", 32'(alloc_ready), 32'd1);
      chk("t3_tail_kept", 32'(alloc_tag), 32'd2);
      flush = 1'b1;
      tick(); flush = 1'b0; #1;
      chk("t3_flushed", 32'(count), 32'd0);

      // 4: 20 instructions through, tags wrap 15 -> 0
      for (int i = 0; i < 20; i++) begin
         alloc_req = 1'b1; alloc_arch_num = 5'(i + 8); #1;
         chk("t4_tag", 32'(alloc_tag), 32'(i % 16));
         tick(); alloc_req = 1'b0;
         cdb = '{valid: 1'b1, tag: 4'(i % 16), data: 32'h1000 + 32'(i)}; #1;
         chk("t4_pre_commit", 32'(commit_valid), 32'd0);
         tick(); cdb = '0; #1;
         chk("t4_commit_valid", 32'(commit_valid), 32'd1);
         chk("t4_commit_arch", 32'(commit_arch_num), 32'((i + 8) % 32));
         chk("t4_commit_data", commit_data, 32'h1000 + 32'(i));
         chk("t4_commit_tag", 32'(commit_tag), 32'(i % 16));
         tick();
      end
      #1;
      chk("t4_empty", 32'(count), 32'd0);

      // 5: read-port bypass, then read from entry; stray CDB ignored
      alloc_req = 1'b1; alloc_arch_num = 5'd9; #1;
      chk("t5_tag4", 32'(alloc_tag), 32'd4);
      tick(); alloc_req = 1'b0;
      cdb = '{valid: 1'b1, tag: 4'd4, data: 32'h1234};
      rd_tag[0] = 4'd4; rd_tag[1] = 4'd5; #1;
      chk("t5_byp_valid", 32'(rd_valid[0]), 32'd1);
      chk("t5_byp_data", rd_data[0], 32'h1234);
      chk("t5_other_valid", 32'(rd_valid[1]), 32'd0);
      tick(); cdb = '{valid: 1'b1, tag: 4'd9, data: 32'hDEAD}; #1;
      chk("t5_ent_valid", 32'(rd_valid[0]), 32'd1);
      chk("t5_ent_data", rd_data[0], 32'h1234);
      tick(); cdb = '0; rd_tag[1] = 4'd9; #1;
      chk("t5_stray_ignored", 32'(rd_valid[1]), 32'd0);
      chk("t5_after_commit", 32'(count), 32'd0);

      // 6: flush dominates alloc and CDB in the same cycle
      alloc_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         alloc_arch_num = 5'(i); tick();
      end
      #1;
      chk("t6_count5", 32'(count), 32'd5);
      flush = 1'b1;
      cdb = '{valid: 1'b1, tag: 4'd5, data: 32'h77};
      tick(); flush = 1'b0; alloc_req = 1'b0; cdb = '0; rd_tag[0] = 4'd5; #1;
      chk("t6_count0", 32'(count), 32'd0);
      chk("t6_commit_valid", 32'(commit_valid), 32'd0);
      chk("t6_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("t6_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("t6_rd_cleared", 32'(rd_valid[0]), 32'd0);

      // Asynchronous reset in the middle of a cycle
      alloc_req = 1'b1; tick(); tick(); alloc_req = 1'b0; #1;
      chk("ar_count2", 32'(count), 32'd2);
      #1; rst_n = 1'b0; #1;
      chk("ar_count0", 32'(count), 32'd0);
      chk("ar_alloc_tag", 32'(alloc_tag), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      tick(); #1;
      chk("ar_ready", 32'(alloc_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
